vscale_dmem_responder: RTL and testbench

//  Data-memory responder (target side) of the core's dmem port: word-organised scratchpad that

---
 rtl/vscale_mem_pkg.sv | 34 +++
 rtl/vscale_dmem_wait_gen.sv | 54 +++++
 rtl/vscale_dmem_responder.sv | 124 ++++++++++++
 tb/tb_vscale_dmem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_mem_pkg.sv
// Shared dmem definitions: FSM states, MEM_TYPE size codes,
// byte-enable helper and LFSR constants.
package vscale_mem_pkg;

  typedef enum logic {
    IDLE,
    DATA
  } dmem_state_t;

  localparam logic [2:0] MEM_TYPE_B  = 3'd0;
  localparam logic [2:0] MEM_TYPE_H  = 3'd1;
  localparam logic [2:0] MEM_TYPE_W  = 3'd2;
  localparam logic [2:0] MEM_TYPE_BU = 3'd4;
  localparam logic [2:0] MEM_TYPE_HU = 3'd5;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // taps 8,6,5,4 -> state bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [3:0] be_from_size(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << a;
      2'd1:    be = 4'b0011 << a;
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/vscale_dmem_wait_gen.sv
// Wait-state generator: loads W on accept, counts down in DATA.
// Ports: accept_i, active_i (data phase) in; wait_o out.
// DMEM_LFSR_WAIT_EN selects W = lfsr[1:0] instead of WAIT_CYCLES.
module vscale_dmem_wait_gen
  import vscale_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic accept_i,
  input  logic active_i,
  output logic wait_o
);

  logic [3:0] cnt_q, cnt_d;
  logic [3:0] load_w;

`ifdef DMEM_LFSR_WAIT_EN
  logic [7:0] lfsr_q, lfsr_d;

  // current value sets this access's W, then steps once
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept_i)
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  assign load_w = {2'b00, lfsr_q[1:0]};

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign load_w = 4'(WAIT_CYCLES);
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (accept_i)
      cnt_d = load_w;
    else if (active_i && cnt_q != 4'd0)
      cnt_d = cnt_q - 4'd1;
  end

  assign wait_o = active_i && (cnt_q != 4'd0);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Data-memory target: word scratchpad with delayed write data,
// wait states and bad-access flag. Ports: dmem_en/wen/size/addr,
// dmem_wdata_delayed in; dmem_rdata, dmem_wait, dmem_badmem_e out.
// Optional DMEM_LFSR_WAIT_EN: pseudo-random 0..3 wait states.
module vscale_dmem_responder
  import vscale_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  dmem_state_t state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [1:0]  size_q, size_d;

  logic             accept, active, last;
  logic [31:0]      off;
  logic             in_range, misalign, bad;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      rd_word, wr_word;
  logic             we;
  logic             unused_size;

  logic [31:0] mem_q [DEPTH_WORDS];

  // signedness bit only matters to the core's load extraction
  assign unused_size = dmem_size[2];

  assign active = (state_q == DATA);
  assign accept = dmem_en && !dmem_wait;
  assign last   = active && !dmem_wait;

  vscale_dmem_wait_gen #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait (
    .clk      (clk),
    .reset    (reset),
    .accept_i (accept),
    .active_i (active),
    .wait_o   (dmem_wait)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    size_d  = size_q;
    if (accept) begin
      state_d = DATA;
      addr_d  = dmem_addr;
      wen_d   = dmem_wen;
      size_d  = dmem_size[1:0];
    end else if (last) begin
      state_d = IDLE;
    end
  end

  assign off      = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign idx      = off[IDX_W+1:2];

  always_comb begin
    case (size_q)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = addr_q[0];
      2'd2:    misalign = (addr_q[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

  assign bad = !in_range || misalign;

  assign rd_word       = mem_q[idx];
  assign dmem_rdata    = (active && !bad) ? rd_word : 32'h0;
  assign dmem_badmem_e = last && bad;

  assign be = be_from_size(size_q, addr_q[1:0]);
  assign we = last && wen_q && !bad;

  always_comb begin
    wr_word = rd_word;
    for (int i = 0; i < 4; i++)
      if (be[i])
        wr_word[8*i +: 8] = dmem_wdata_delayed[8*i +: 8];
  end

  // a reset in the final cycle discards the store
  always_ff @(posedge clk) begin
    if (!reset && we)
      mem_q[idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wen_q   <= 1'b0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
    end
  end

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Scoreboard bench for vscale_dmem_responder: directed and
// random accesses checked against a byte-level memory model.
module tb_vscale_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          WAIT  = 2;

  logic        clk = 0;
  logic        reset = 1;
  logic        dmem_en = 0;
  logic        dmem_wen = 0;
  logic [2:0]  dmem_size = 0;
  logic [31:0] dmem_addr = 0;
  logic [31:0] dmem_wdata_delayed = 0;
  logic [31:0] dmem_rdata;
  logic        dmem_wait;
  logic        dmem_badmem_e;

  always #5 clk = ~clk;

  vscale_dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .dmem_en            (dmem_en),
    .dmem_wen           (dmem_wen),
    .dmem_size          (dmem_size),
    .dmem_addr          (dmem_addr),
    .dmem_wdata_delayed (dmem_wdata_delayed),
    .dmem_rdata         (dmem_rdata),
    .dmem_wait          (dmem_wait),
    .dmem_badmem_e      (dmem_badmem_e)
  );

  typedef struct {
    logic [31:0] rdata;
    bit          bad;
    int          waits;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mm [int];
  logic [7:0]  m_lfsr = 8'hA5;
  int          total = 0;
  int          bad_cnt = 0;

  function automatic int model_wait();
    int w;
`ifdef DMEM_LFSR_WAIT_EN
    w = int'(m_lfsr % 4);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`else
    w = WAIT;
`endif
    return w;
  endfunction

  function automatic bit is_bad(logic [2:0] sz, logic [31:0] a);
    if (a < BASE || (a - BASE) >= 32'(DEPTH * 4)) return 1;
    case (sz[1:0])
      2'd0:    return 0;
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'b00;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(logic [31:0] a);
    int k = int'((a - BASE) >> 2);
    return mm.exists(k) ? mm[k] : 32'h0;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // one access: hold the request until accepted, then drive data
  task automatic issue(bit w, logic [2:0] sz, logic [31:0] a,
                       logic [31:0] d, bit push);
    exp_t e;
    int   n = 0;
    int   k;
    dmem_en = 1; dmem_wen = w; dmem_size = sz; dmem_addr = a;
    @(negedge clk);
    while (dmem_wait && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (dmem_wait) begin
      total++; bad_cnt++;
      $display("FAIL accept_timeout: addr %h never accepted", a);
    end
    e.waits = model_wait();
    e.bad   = is_bad(sz, a);
    e.addr  = a;
    e.rdata = e.bad ? 32'h0 : rd_model(a);
    if (push) begin
      if (w && !e.bad) begin
        logic [31:0] word = e.rdata;
        int nb = 1 << sz[1:0];
        for (int i = 0; i < nb; i++) begin
          int ln = int'(a % 4) + i;
          word[8*ln +: 8] = d[8*ln +: 8];
        end
        k = int'((a - BASE) >> 2);
        mm[k] = word;
      end
      sb.push_back(e);
    end
    @(posedge clk); #1;
    dmem_en = 0;
    dmem_wdata_delayed = d;
  endtask

  task automatic gap(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // monitor: tracks data phases from observed accepts
  bit   in_data = 0;
  int   wcnt = 0;
  exp_t me;
  always @(negedge clk) begin
    if (reset) begin
      in_data = 0;
      wcnt = 0;
    end else if (in_data) begin
      if (dmem_wait) begin
        wcnt++;
        check("badmem_in_wait", 32'(dmem_badmem_e), 32'h0);
      end else begin
        if (sb.size() == 0) begin
          total++; bad_cnt++;
          $display("FAIL unexpected_resp: rdata %h no expectation", dmem_rdata);
        end else begin
          me = sb.pop_front();
          check($sformatf("rdata@%h", me.addr), dmem_rdata, me.rdata);
          check($sformatf("badmem@%h", me.addr), 32'(dmem_badmem_e), 32'(me.bad));
          check($sformatf("waits@%h", me.addr), 32'(wcnt), 32'(me.waits));
        end
        wcnt = 0;
        in_data = dmem_en;
      end
    end else begin
      check("idle_wait", 32'(dmem_wait), 32'h0);
      check("idle_badmem", 32'(dmem_badmem_e), 32'h0);
      check("idle_rdata", dmem_rdata, 32'h0);
      in_data = dmem_en;
    end
  end

  initial begin
    gap(3);
    reset = 0;
    gap(2);

    // store then back-to-back load
    issue(1, 3'd2, 32'h100, 32'h12345678, 1);
    issue(0, 3'd2, 32'h100, 32'h0, 1);
    gap(1);

    // sub-word stores
    issue(1, 3'd2, 32'h100, 32'h0, 1);
    issue(1, 3'd0, 32'h103, 32'hABABABAB, 1);
    issue(0, 3'd2, 32'h100, 32'h0, 1);
    issue(1, 3'd2, 32'h100, 32'h0, 1);
    issue(1, 3'd1, 32'h102, 32'hBEEFBEEF, 1);
    issue(0, 3'd2, 32'h100, 32'h0, 1);
    issue(0, 3'd4, 32'h102, 32'h0, 1);

    // bad accesses
    issue(0, 3'd2, BASE + 32'(DEPTH * 4), 32'h0, 1);
    issue(0, 3'd2, 32'hFFFF_FFFC, 32'h0, 1);
    issue(1, 3'd1, 32'h101, 32'h55555555, 1);
    issue(1, 3'd3, 32'h100, 32'h66666666, 1);
    issue(0, 3'd2, 32'h102, 32'h0, 1);
    issue(0, 3'd2, 32'h100, 32'h0, 1);

    // reset during the second data-phase cycle of a store
    issue(1, 3'd2, 32'h200, 32'h0BADF00D, 1);
    gap(2);
    issue(1, 3'd2, 32'h200, 32'hDEADBEEF, 0);
    gap(1);
    reset = 1;
    m_lfsr = 8'hA5;
    gap(1);
    reset = 0;
    gap(1);
    issue(0, 3'd2, 32'h200, 32'h0, 1);

    // preload window, then random traffic
    for (int i = 0; i < 16; i++)
      issue(1, 3'd2, 32'h100 + 32'(4 * i), $urandom, 1);
    issue(1, 3'd2, BASE + 32'(DEPTH * 4 - 4), $urandom, 1);
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  sz;
      logic [31:0] a;
      sz = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0)
        a = BASE + 32'(DEPTH * 4 - 4) + 32'($urandom_range(0, 11));
      else
        a = 32'h100 + 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), sz, a, $urandom, 1);
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 2));
    end

    for (int i = 0; i < 60 && sb.size() != 0; i++) gap(1);
    gap(2);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad_cnt);
    $finish;
  end

endmodule
